// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM-stage data memory controller: FSM states,
// RV64 load/store funct3 encodings and an alignment helper.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RMW_RD = 2'd2,
      ST_RMW_WR = 2'd3
   } state_t;

   localparam logic [2:0] F3_B   = 3'b000;
   localparam logic [2:0] F3_H   = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [2:0] F3_BU  = 3'b100;
   localparam logic [2:0] F3_HU  = 3'b101;
   localparam logic [2:0] F3_WU  = 3'b110;
   localparam logic [2:0] F3_BAD = 3'b111;

   // funct3[1:0] encodes log2 of the access size in bytes.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'b01:   return off[0];
         2'b10:   return |off[1:0];
         2'b11:   return |off;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane datapath: load extraction with sign/zero extension, and the
// read-modify-write merge of store bytes into a fetched doubleword.
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [2:0]  i_byte_off,
   input  logic [63:0] i_rdata,
   input  logic [63:0] i_wdata,
   output logic [63:0] o_load_data,
   output logic [63:0] o_merge_data
);

   logic [5:0]  w_shamt;
   logic [63:0] w_shifted;
   logic [63:0] w_size_mask;
   logic [63:0] w_lane_mask;

   assign w_shamt   = {i_byte_off, 3'b000};
   assign w_shifted = i_rdata >> w_shamt;

   always_comb begin
      o_load_data = w_shifted;
      case (i_funct3)
         F3_B:    o_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
         F3_H:    o_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
         F3_W:    o_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
         F3_D:    o_load_data = w_shifted;
         F3_BU:   o_load_data = {56'd0, w_shifted[7:0]};
         F3_HU:   o_load_data = {48'd0, w_shifted[15:0]};
         F3_WU:   o_load_data = {32'd0, w_shifted[31:0]};
         default: o_load_data = w_shifted;
      endcase
   end

   always_comb begin
      w_size_mask = '1;
      case (i_funct3[1:0])
         2'b00:   w_size_mask = 64'h0000_0000_0000_00FF;
         2'b01:   w_size_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   w_size_mask = 64'h0000_0000_FFFF_FFFF;
         default: w_size_mask = '1;
      endcase
   end

   assign w_lane_mask  = w_size_mask << w_shamt;
   assign o_merge_data = (i_rdata & ~w_lane_mask) | ((i_wdata << w_shamt) & w_lane_mask);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: multi-cycle loads, single-cycle doubleword stores
// and read-modify-write for sub-doubleword stores, with alignment checks.
//
// state     | meaning
// ST_IDLE   | sample request; reject, issue sd write, or start a read
// ST_LOAD   | dm_rdata valid; extract/extend lanes into rdata_out
// ST_RMW_RD | dm_rdata valid; capture merged doubleword
// ST_RMW_WR | write merged doubleword back
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [63:0]       addr,
   input  logic [63:0]       wdata,
   input  logic              branch,
   input  logic              zero,
   output logic              stall,
   output logic [63:0]       rdata_out,
   output logic              rdata_valid,
   output logic              access_err,
   output logic              pc_src,
   output logic              dm_mem_read,
   output logic              dm_mem_write,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [63:0]       dm_wdata,
   input  logic [63:0]       dm_rdata
);

   state_t      r_state;
   state_t      w_next;
   logic [63:0] r_rdata;
   logic [63:0] r_merge;
   logic        r_rdata_valid;
   logic        w_load_done;
   logic        w_reject;
   logic [63:0] w_load_data;
   logic [63:0] w_merge_data;
   logic        w_unused;

   assign w_unused = ^addr[63:ADDR_W+3];
   assign pc_src   = branch & zero;
   assign dm_addr  = addr[ADDR_W+2:3];

   assign w_reject = (mem_read & mem_write)
                   | (mem_read & (funct3 == F3_BAD))
                   | (mem_write & funct3[2])
                   | is_misaligned(funct3[1:0], addr[2:0]);

   mem_lane_align u_align (
      .i_funct3     (funct3),
      .i_byte_off   (addr[2:0]),
      .i_rdata      (dm_rdata),
      .i_wdata      (wdata),
      .o_load_data  (w_load_data),
      .o_merge_data (w_merge_data)
   );

   always_comb begin
      w_next       = r_state;
      stall        = 1'b0;
      access_err   = 1'b0;
      dm_mem_read  = 1'b0;
      dm_mem_write = 1'b0;
      dm_wdata     = wdata;
      w_load_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid && (mem_read || mem_write)) begin
               if (w_reject) begin
                  access_err = 1'b1;
               end else if (mem_read) begin
                  dm_mem_read = 1'b1;
                  stall       = 1'b1;
                  w_next      = ST_LOAD;
               end else if (funct3 == F3_D) begin
                  dm_mem_write = 1'b1;
               end else begin
                  dm_mem_read = 1'b1;
                  stall       = 1'b1;
                  w_next      = ST_RMW_RD;
               end
            end
         end
         ST_LOAD: begin
            stall       = 1'b1;
            w_load_done = 1'b1;
            w_next      = ST_IDLE;
         end
         ST_RMW_RD: begin
            stall  = 1'b1;
            w_next = ST_RMW_WR;
         end
         ST_RMW_WR: begin
            dm_mem_write = 1'b1;
            dm_wdata     = r_merge;
            w_next       = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      // Reset kills the access in the same cycle, including a pending write-back.
      if (reset) begin
         w_next       = ST_IDLE;
         stall        = 1'b0;
         access_err   = 1'b0;
         dm_mem_read  = 1'b0;
         dm_mem_write = 1'b0;
         w_load_done  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_rdata       <= '0;
         r_merge       <= '0;
         r_rdata_valid <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_rdata_valid <= w_load_done;
         if (w_load_done) begin
            r_rdata <= w_load_data;
         end
         if (r_state == ST_RMW_RD) begin
            r_merge <= w_merge_data;
         end
      end
   end

   assign rdata_out   = reset ? '0 : r_rdata;
   assign rdata_valid = r_rdata_valid & ~reset;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table driven through a
// scoreboard against a behavioural data memory, plus reset/branch sequences.
module tb_mem_access_ctrl;

   typedef enum logic [1:0] {K_NONE, K_LOAD, K_STORE, K_ERR} kind_t;

   typedef struct {
      kind_t       kind;
      logic        rv;
      logic        mr;
      logic        mw;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] init;
      logic [63:0] exp_val;
      int          exp_stall;
   } vec_t;

   localparam logic [63:0] W = 64'h8877_6655_4433_2211;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        branch;
   logic        zero;
   logic        stall;
   logic [63:0] rdata_out;
   logic        rdata_valid;
   logic        access_err;
   logic        pc_src;
   logic        dm_mem_read;
   logic        dm_mem_write;
   logic [9:0]  dm_addr;
   logic [63:0] dm_wdata;
   logic [63:0] dm_rdata;

   logic [63:0] mem [0:1023];
   logic        pre_we;
   logic [9:0]  pre_idx;
   logic [63:0] pre_data;

   int          n_checks;
   int          n_fail;
   logic [63:0] last_rd;
   vec_t        sb_q[$];
   vec_t        vecs[$];

   mem_access_ctrl #(.ADDR_W(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .funct3       (funct3),
      .addr         (addr),
      .wdata        (wdata),
      .branch       (branch),
      .zero         (zero),
      .stall        (stall),
      .rdata_out    (rdata_out),
      .rdata_valid  (rdata_valid),
      .access_err   (access_err),
      .pc_src       (pc_src),
      .dm_mem_read  (dm_mem_read),
      .dm_mem_write (dm_mem_write),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      else if (dm_mem_write) mem[dm_addr] <= dm_wdata;
      if (dm_mem_read) dm_rdata <= mem[dm_addr];
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic drive_idle();
      req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      funct3 = 3'b000; addr = '0; wdata = '0;
   endtask

   task automatic drive(input vec_t v);
      req_valid = v.rv; mem_read = v.mr; mem_write = v.mw;
      funct3 = v.f3; addr = v.addr; wdata = v.wdata;
   endtask

   task automatic preload(input logic [9:0] idx, input logic [63:0] data);
      @(negedge clk);
      drive_idle();
      pre_we = 1'b1; pre_idx = idx; pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   function automatic vec_t mk(input kind_t k, input logic rv, input logic mr, input logic mw,
                               input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                               input logic [63:0] init, input logic [63:0] ev, input int st);
      vec_t v;
      v.kind = k; v.rv = rv; v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = a;
      v.wdata = wd; v.init = init; v.exp_val = ev; v.exp_stall = st;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      vec_t        e;
      int          n_stall;
      int          ev_cyc;
      int          hold;
      logic        both;
      logic        got;
      logic [9:0]  idx;
      idx = v.addr[12:3];
      preload(idx, v.init);
      if (v.kind == K_LOAD) hold = 2;
      else if (v.kind == K_STORE && v.exp_stall > 0) hold = 3;
      else hold = 1;
      n_stall = 0; ev_cyc = -1; both = 1'b0; got = 1'b0;
      sb_q.push_back(v);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c < hold) drive(v);
         else drive_idle();
         #1;
         if (stall) n_stall++;
         if (dm_mem_read && dm_mem_write) both = 1'b1;
         if (dm_mem_read || dm_mem_write) chk("dm_addr", 64'(dm_addr), 64'(idx));
         if (got && c == ev_cyc + 1) chk("pulse_width", {62'd0, rdata_valid, access_err}, 64'd0);
         if (!got && (rdata_valid || access_err || dm_mem_write)) begin
            got = 1'b1; ev_cyc = c;
            e = sb_q.pop_front();
            case (e.kind)
               K_LOAD: begin
                  chk("load_valid", 64'(rdata_valid), 64'd1);
                  chk("load_data", rdata_out, e.exp_val);
                  last_rd = e.exp_val;
               end
               K_STORE: begin
                  chk("store_strobe", 64'(dm_mem_write), 64'd1);
                  chk("store_wdata", dm_wdata, e.exp_val);
               end
               K_ERR: begin
                  chk("err_pulse", 64'(access_err), 64'd1);
                  chk("err_quiet", {61'd0, dm_mem_read, dm_mem_write, stall}, 64'd0);
               end
               default: chk("unexpected_event", {61'd0, rdata_valid, access_err, dm_mem_write}, 64'd0);
            endcase
         end
      end
      if (!got) begin
         e = sb_q.pop_front();
         if (e.kind != K_NONE) chk("event_timeout", 64'(got), 64'd1);
      end else begin
         chk("event_cycle", 64'(ev_cyc), 64'(v.exp_stall));
      end
      chk("stall_cycles", 64'(n_stall), 64'(v.exp_stall));
      chk("rw_exclusive", 64'(both), 64'd0);
      chk("rdata_hold", rdata_out, last_rd);
      chk("mem_word", mem[idx], (v.kind == K_STORE) ? v.exp_val : v.init);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic       saw_wr;
      logic [2:0] pc_tab [4];
      n_checks = 0; n_fail = 0; last_rd = '0;
      pre_we = 1'b0; pre_idx = '0; pre_data = '0;
      branch = 1'b0; zero = 1'b0;
      dm_rdata = '0;

      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b011, 64'h10, 64'h0, W, W, 2));
      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b000, 64'h17, 64'h0, W, 64'hFFFF_FFFF_FFFF_FF88, 2));
      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b100, 64'h17, 64'h0, W, 64'h0000_0000_0000_0088, 2));
      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b001, 64'h12, 64'h0, W, 64'h0000_0000_0000_4433, 2));
      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b101, 64'h16, 64'h0, W, 64'h0000_0000_0000_8877, 2));
      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b001, 64'h16, 64'h0, W, 64'hFFFF_FFFF_FFFF_8877, 2));
      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b010, 64'h14, 64'h0, W, 64'hFFFF_FFFF_8877_6655, 2));
      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b110, 64'h14, 64'h0, W, 64'h0000_0000_8877_6655, 2));
      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b010, 64'h10, 64'h0, W, 64'h0000_0000_4433_2211, 2));
      vecs.push_back(mk(K_LOAD,  1, 1, 0, 3'b011, 64'hFFFF_0000_0000_2010, 64'h0, W, W, 2));
      vecs.push_back(mk(K_STORE, 1, 0, 1, 3'b000, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, W, 64'h8877_6655_AB33_2211, 2));
      vecs.push_back(mk(K_STORE, 1, 0, 1, 3'b001, 64'h16, 64'h0000_0000_0000_BEEF, W, 64'hBEEF_6655_4433_2211, 2));
      vecs.push_back(mk(K_STORE, 1, 0, 1, 3'b010, 64'h14, 64'h0000_0000_DEAD_BEEF, W, 64'hDEAD_BEEF_4433_2211, 2));
      vecs.push_back(mk(K_STORE, 1, 0, 1, 3'b000, 64'h10, 64'h0000_0000_0000_005A, W, 64'h8877_6655_4433_225A, 2));
      vecs.push_back(mk(K_STORE, 1, 0, 1, 3'b011, 64'h08, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF, 0));
      vecs.push_back(mk(K_ERR,   1, 0, 1, 3'b010, 64'h12, 64'h1111_1111, W, 64'h0, 0));
      vecs.push_back(mk(K_ERR,   1, 1, 0, 3'b001, 64'h11, 64'h0, W, 64'h0, 0));
      vecs.push_back(mk(K_ERR,   1, 1, 0, 3'b011, 64'h14, 64'h0, W, 64'h0, 0));
      vecs.push_back(mk(K_ERR,   1, 1, 0, 3'b111, 64'h10, 64'h0, W, 64'h0, 0));
      vecs.push_back(mk(K_ERR,   1, 0, 1, 3'b100, 64'h10, 64'h55, W, 64'h0, 0));
      vecs.push_back(mk(K_ERR,   1, 1, 1, 3'b011, 64'h10, 64'h55, W, 64'h0, 0));
      vecs.push_back(mk(K_NONE,  0, 1, 0, 3'b011, 64'h10, 64'h0, W, 64'h0, 0));
      vecs.push_back(mk(K_NONE,  1, 0, 0, 3'b011, 64'h10, 64'h0, W, 64'h0, 0));

      // Reset state, with a load request presented while reset is high.
      reset = 1'b1;
      drive_idle();
      req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b011; addr = 64'h10;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_strobes", {61'd0, stall, dm_mem_read, dm_mem_write}, 64'd0);
      chk("rst_pulses", {62'd0, rdata_valid, access_err}, 64'd0);
      chk("rst_rdata", rdata_out, 64'd0);
      drive_idle();
      @(negedge clk);
      reset = 1'b0;

      pc_tab[0] = 3'b000; pc_tab[1] = 3'b010; pc_tab[2] = 3'b100; pc_tab[3] = 3'b111;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         branch = pc_tab[i][2]; zero = pc_tab[i][1];
         #1;
         chk("pc_src", 64'(pc_src), 64'(pc_tab[i][0]));
      end
      branch = 1'b0; zero = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset while the sh read-modify-write sits in its read-back cycle.
      preload(10'd3, W);
      @(negedge clk);
      req_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0;
      funct3 = 3'b001; addr = 64'h1A; wdata = 64'h1234;
      #1;
      chk("rmw_rst_c0", {62'd0, stall, dm_mem_read}, 64'd3);
      @(negedge clk);
      reset = 1'b1;
      #1;
      saw_wr = dm_mem_write;
      chk("rmw_rst_c1", {62'd0, stall, dm_mem_read}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      drive_idle();
      for (int c = 0; c < 3; c++) begin
         #1;
         if (dm_mem_write) saw_wr = 1'b1;
         @(negedge clk);
      end
      chk("rmw_rst_no_write", 64'(saw_wr), 64'd0);
      chk("rmw_rst_mem", mem[3], W);
      chk("rmw_rst_rdata", rdata_out, 64'd0);
      last_rd = '0;
      run_vec(mk(K_LOAD, 1, 1, 0, 3'b011, 64'h18, 64'h0, W, W, 2));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
